// File: rtl/bayer_rgb_dec.sv
// bayer_rgb_dec -- Bayer-to-RGB 2x2 decimating demosaic.
//
// Takes one raw Bayer pixel per valid cycle and produces one RGB pixel
// per 2x2 quad, so the output image is (W/2)x(H/2). Each even row is
// packed two pixels per entry into an internal line buffer. On the
// following odd row that entry is read back and combined with the
// current pixel pair to form the quad.
//
// Ports:
//   p_clk       pixel clock; all logic runs on its rising edge
//   rst         synchronous active-high reset
//   i_sof       start of frame: latches i_width/i_pattern and clears x/y
//   i_width     active line width in pixels (even, 2..MAX_W)
//   i_pattern   Bayer phase of the top-left pixel: 0=RGGB 1=GRBG 2=GBRG 3=BGGR
//   i_data_val  i_data is valid this cycle
//   i_data      raw pixel
//   o_red/o_green/o_blue  colour of the last completed quad (held)
//   o_data_val  one-cycle strobe, one cycle after the quad's last pixel
//   o_x/o_y     decimated coordinates of the output pixel
//   o_cfg_err   the width latched for this frame is invalid
//
// Build option: define BAYER_GREEN_AVG_EN to output the floor average of
// both green samples. Without it, green is the top-row green sample.
module bayer_rgb_dec #(
    parameter int DATA_W = 12,
    parameter int MAX_W  = 1280,
    parameter int CNT_W  = 16
) (
    input  logic              p_clk,
    input  logic              rst,
    input  logic              i_sof,
    input  logic [CNT_W-1:0]  i_width,
    input  logic [1:0]        i_pattern,
    input  logic              i_data_val,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_red,
    output logic [DATA_W-1:0] o_green,
    output logic [DATA_W-1:0] o_blue,
    output logic              o_data_val,
    output logic [CNT_W-1:0]  o_x,
    output logic [CNT_W-1:0]  o_y,
    output logic              o_cfg_err
);

    localparam int HALF_W = MAX_W / 2;
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t              state;
    logic [CNT_W-1:0]    width_r, x, y;
    logic [1:0]          pat_r;
    logic [DATA_W-1:0]   hold_p0;      // even-x pixel: top pair left, or B0
    logic [2*DATA_W-1:0] rd_p0;        // {T0, T1} read back for the odd row
    logic [2*DATA_W-1:0] line_mem [HALF_W];

`ifdef BAYER_GREEN_AVG_EN
    // The sum is one bit wider than a sample, so it cannot overflow.
    // The shift then gives the floor of the average.
    function automatic logic [DATA_W-1:0] green_avg(input logic [DATA_W-1:0] ga,
                                                    input logic [DATA_W-1:0] gb);
        logic [DATA_W:0] sum;
        sum = {1'b0, ga} + {1'b0, gb};
        return sum[DATA_W:1];
    endfunction
`endif

    // An i_sof cycle acts on its own configuration and counters, so a
    // pixel arriving with i_sof is treated as (0,0) of the new frame.
    logic              width_ok, cur_run, accept, last_x, wr_en, quad_done;
    logic [CNT_W-1:0]  cur_x, cur_y, cur_w, half_x;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] t0, t1, red_c, blue_c, ga_c, green_c;

    assign width_ok  = !i_width[0] && (i_width >= CNT_W'(2)) && (i_width <= CNT_W'(MAX_W));
    assign cur_x     = i_sof ? '0 : x;
    assign cur_y     = i_sof ? '0 : y;
    assign cur_w     = i_sof ? i_width : width_r;
    assign cur_run   = i_sof ? width_ok : (state == RUN);
    assign accept    = i_data_val && cur_run;
    assign last_x    = (cur_x == cur_w - 1'b1);
    assign half_x    = cur_x >> 1;
    assign addr      = half_x[AW-1:0];
    assign wr_en     = accept && !cur_y[0] && cur_x[0];
    assign quad_done = accept && cur_y[0] && cur_x[0];
    assign t0        = rd_p0[2*DATA_W-1:DATA_W];
    assign t1        = rd_p0[DATA_W-1:0];

    // Quad mapping. B0 = hold_p0 and B1 = i_data. ga_c is always the
    // top-row green sample.
    always_comb begin
        red_c  = t0;
        blue_c = i_data;
        ga_c   = t1;
        case (pat_r)
            2'd0: begin red_c = t0;      blue_c = i_data;  ga_c = t1; end
            2'd1: begin red_c = t1;      blue_c = hold_p0; ga_c = t0; end
            2'd2: begin red_c = hold_p0; blue_c = t1;      ga_c = t0; end
            default: begin red_c = i_data; blue_c = t0;    ga_c = t1; end
        endcase
    end

`ifdef BAYER_GREEN_AVG_EN
    logic [DATA_W-1:0] gb_c;
    always_comb begin
        gb_c = hold_p0;
        case (pat_r)
            2'd1, 2'd2: gb_c = i_data;
            default:    gb_c = hold_p0;
        endcase
    end
    assign green_c = green_avg(ga_c, gb_c);
`else
    assign green_c = ga_c;
`endif

    // Line buffer: one entry per horizontal pixel pair of an even row.
    always_ff @(posedge p_clk) begin
        if (wr_en)
            line_mem[addr] <= {hold_p0, i_data};
    end

    // p0: accept pixel, update counters/holds; quad result registered to outputs
    always_ff @(posedge p_clk) begin
        if (rst) begin
            state      <= IDLE;
            width_r    <= '0;
            pat_r      <= '0;
            x          <= '0;
            y          <= '0;
            hold_p0    <= '0;
            rd_p0      <= '0;
            o_red      <= '0;
            o_green    <= '0;
            o_blue     <= '0;
            o_data_val <= 1'b0;
            o_x        <= '0;
            o_y        <= '0;
            o_cfg_err  <= 1'b0;
        end else begin
            o_data_val <= quad_done;
            if (i_sof) begin
                width_r   <= i_width;
                pat_r     <= i_pattern;
                state     <= width_ok ? RUN : ERR;
                o_cfg_err <= !width_ok;
                x         <= '0;
                y         <= '0;
            end
            if (accept) begin
                if (last_x) begin
                    x <= '0;
                    y <= cur_y + 1'b1;
                end else begin
                    x <= cur_x + 1'b1;
                end
                if (!cur_x[0])
                    hold_p0 <= i_data;
                if (cur_y[0] && !cur_x[0])
                    rd_p0 <= line_mem[addr];
            end
            if (quad_done) begin
                o_red   <= red_c;
                o_green <= green_c;
                o_blue  <= blue_c;
                o_x     <= cur_x >> 1;
                o_y     <= cur_y >> 1;
            end
        end
    end

endmodule

// File: tb/tb_bayer_rgb_dec.sv
// tb_bayer_rgb_dec -- directed self-checking bench for bayer_rgb_dec.
// Expected colours are hand-computed for both builds of BAYER_GREEN_AVG_EN.
module tb_bayer_rgb_dec;
    localparam int DW = 12;
    localparam int CW = 16;

    logic          p_clk = 1'b0;
    logic          rst, i_sof, i_data_val;
    logic [CW-1:0] i_width;
    logic [1:0]    i_pattern;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_red, o_green, o_blue;
    logic          o_data_val, o_cfg_err;
    logic [CW-1:0] o_x, o_y;

    bayer_rgb_dec #(.DATA_W(DW), .MAX_W(1280), .CNT_W(CW)) dut (
        .p_clk(p_clk), .rst(rst), .i_sof(i_sof), .i_width(i_width),
        .i_pattern(i_pattern), .i_data_val(i_data_val), .i_data(i_data),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_data_val(o_data_val), .o_x(o_x), .o_y(o_y), .o_cfg_err(o_cfg_err)
    );

    always #5 p_clk = ~p_clk;

    int cyc = 0;
    always @(posedge p_clk) cyc <= cyc + 1;

    typedef struct {int x; int y; int r; int g; int b; int c;} out_t;
    out_t oq[$];
    int   b1q[$];
    int   pix[$];

    always @(negedge p_clk)
        if (o_data_val)
            oq.push_back('{int'(o_x), int'(o_y), int'(o_red), int'(o_green), int'(o_blue), cyc});

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; width/pattern carry junk outside i_sof.
    task automatic drive(input bit sof, input bit val, input int d, input int w, input int pat);
        @(negedge p_clk);
        i_sof      = sof;
        i_data_val = val;
        i_data     = DW'(d);
        if (sof) begin
            i_width   = CW'(w);
            i_pattern = 2'(pat);
        end else begin
            i_width   = CW'($urandom);
            i_pattern = 2'($urandom);
        end
    endtask

    // mode 0: i_sof cycle before pixels, 1: i_sof with first pixel, 2: no i_sof
    task automatic send_frame(input int w, input int pat, input int maxgap,
                              input int mode, input bit tail_sof);
        if (mode == 0) drive(1, 0, 0, w, pat);
        foreach (pix[i]) begin
            if (!(mode == 1 && i == 0))
                repeat ($urandom_range(maxgap, 0)) drive(0, 0, int'($urandom), 0, 0);
            drive(mode == 1 && i == 0, 1, pix[i], w, pat);
            if (((i / w) % 2 == 1) && ((i % w) % 2 == 1)) b1q.push_back(cyc);
        end
        drive(tail_sof, 0, 0, 4, 0);
        repeat (3) drive(0, 0, 0, 0, 0);
    endtask

    task automatic check_out(input string tag, input int idx, input int ex, input int ey,
                             input int er, input int eg, input int eb);
        if (idx < oq.size()) begin
            check_val({tag, ".x"}, oq[idx].x, ex);
            check_val({tag, ".y"}, oq[idx].y, ey);
            check_val({tag, ".r"}, oq[idx].r, er);
            check_val({tag, ".g"}, oq[idx].g, eg);
            check_val({tag, ".b"}, oq[idx].b, eb);
        end else begin
            check_val({tag, ".present"}, oq.size(), idx + 1);
        end
    endtask

    task automatic check_lat(input string tag);
        foreach (b1q[i])
            if (i < oq.size()) check_val({tag, ".lat"}, oq[i].c, b1q[i] + 1);
    endtask

    task automatic clear_logs();
        oq.delete();
        b1q.delete();
    endtask

`ifdef BAYER_GREEN_AVG_EN
    localparam int G_RGGB0 = 350, G_RGGB1 = 550, G_BGGR0 = 350, G_GRBG0 = 350, G_MIX = 2052;
`else
    localparam int G_RGGB0 = 200, G_RGGB1 = 400, G_BGGR0 = 200, G_GRBG0 = 100, G_MIX = 10;
`endif

    initial begin
        rst = 1'b1; i_sof = 1'b0; i_data_val = 1'b0; i_data = '0;
        i_width = '0; i_pattern = '0;
        repeat (3) @(negedge p_clk);
        rst = 1'b0;
        @(negedge p_clk);
        check_val("rst.red", int'(o_red), 0);
        check_val("rst.green", int'(o_green), 0);
        check_val("rst.blue", int'(o_blue), 0);
        check_val("rst.val", int'(o_data_val), 0);
        check_val("rst.xy", int'(o_x) + int'(o_y), 0);
        check_val("rst.err", int'(o_cfg_err), 0);

        // RGGB, width 4
        pix = '{100, 200, 300, 400, 500, 600, 700, 800};
        clear_logs();
        send_frame(4, 0, 0, 0, 0);
        check_val("rggb.cnt", oq.size(), 2);
        check_out("rggb.q0", 0, 0, 0, 100, G_RGGB0, 600);
        check_out("rggb.q1", 1, 1, 0, 300, G_RGGB1, 800);
        check_lat("rggb");

        // BGGR, i_sof together with the first pixel
        clear_logs();
        send_frame(4, 3, 0, 1, 0);
        check_val("bggr.cnt", oq.size(), 2);
        check_out("bggr.q0", 0, 0, 0, 600, G_BGGR0, 100);

        // GRBG
        clear_logs();
        send_frame(4, 1, 0, 0, 0);
        check_val("grbg.cnt", oq.size(), 2);
        check_out("grbg.q0", 0, 0, 0, 200, G_GRBG0, 500);

        // RGGB with random gaps
        clear_logs();
        send_frame(4, 0, 5, 0, 0);
        check_val("gap.cnt", oq.size(), 2);
        check_out("gap.q0", 0, 0, 0, 100, G_RGGB0, 600);
        check_out("gap.q1", 1, 1, 0, 300, G_RGGB1, 800);
        check_lat("gap");

        // Invalid width 5, then recovery with width 4
        clear_logs();
        drive(1, 0, 0, 5, 0);
        drive(0, 0, 0, 0, 0);
        check_val("cfg.err1", int'(o_cfg_err), 1);
        send_frame(4, 0, 0, 2, 0);
        check_val("cfg.nostrobe", oq.size(), 0);
        send_frame(4, 0, 0, 0, 0);
        check_val("cfg.err0", int'(o_cfg_err), 0);
        check_val("cfg.cnt", oq.size(), 2);
        check_out("cfg.q0", 0, 0, 0, 100, G_RGGB0, 600);

        // Reset in the middle of row 1, then pixels without i_sof
        clear_logs();
        pix = '{100, 200, 300, 400, 500};
        drive(1, 0, 0, 4, 0);
        foreach (pix[i]) drive(0, 1, pix[i], 0, 0);
        @(negedge p_clk);
        rst = 1'b1; i_data_val = 1'b0; i_sof = 1'b0;
        @(negedge p_clk);
        rst = 1'b0;
        check_val("mrst.red", int'(o_red), 0);
        check_val("mrst.x", int'(o_x), 0);
        pix = '{100, 200, 300, 400, 500, 600, 700, 800};
        send_frame(4, 0, 0, 2, 0);
        check_val("mrst.nostrobe", oq.size(), 0);
        check_val("mrst.err", int'(o_cfg_err), 0);

        // Green extremes, width 2, i_sof right after the last B1
        clear_logs();
        pix = '{7, 4095, 4095, 9, 7, 10, 4095, 9};
        send_frame(2, 0, 0, 0, 1);
        check_val("grn.cnt", oq.size(), 2);
        check_out("grn.q0", 0, 0, 0, 7, 4095, 9);
        check_out("grn.q1", 1, 0, 1, 7, G_MIX, 9);
        check_lat("grn");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bayer_rgb_dec.md
# bayer_rgb_dec

Parametrised Bayer-to-RGB 2x2 decimating demosaic for the camera image-processing path, the successor to the fixed 12-bit raw-to-RGB stage. It accepts one raw pixel per valid cycle from the sensor capture stage, buffers one row internally and emits one RGB pixel per 2x2 Bayer quad. Output resolution is (W/2)x(H/2). It adds runtime line width, runtime Bayer phase selection, frame-start synchronisation, output coordinates and configuration-error detection.

## Interface
- DATA_W, 12: raw and per-channel colour width.
- MAX_W, 1280: maximum line width in pixels; must be even. Line buffer holds MAX_W/2 entries of 2*DATA_W bits.
- CNT_W, 16: width of the coordinate counters and of i_width.
- p_clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_sof  in  1  start-of-frame pulse; latches configuration and clears counters.
- i_width  in  CNT_W  active line width in pixels; sampled only on i_sof.
- i_pattern  in  2  Bayer phase of the top-left pixel; sampled only on i_sof. 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
- i_data_val  in  1  i_data valid this cycle.
- i_data  in  DATA_W  raw pixel.
- o_red, o_green, o_blue  out  DATA_W  colour outputs, held between valids.
- o_data_val  out  1  single-cycle output strobe.
- o_x, o_y  out  CNT_W  decimated coordinates of the output pixel.
- o_cfg_err  out  1  latched width invalid for the current frame.

## Operation
- FSM states:
  - IDLE: after reset; pixels are ignored.
  - RUN
  - ERR: pixels are ignored.
- Transitions:
  - Any state on i_sof with valid width: RUN.
  - Any state on i_sof with invalid width: ERR.
  - rst from any state: IDLE.
- A width is valid when it is even and in the range 2..MAX_W.
- Counters x and y advance only on accepted pixels (i_data_val in RUN).
  - x increments per pixel. At x==W-1, x goes to 0 and y increments.
  - y wraps modulo 2^CNT_W.
  - i_sof clears x and y. If i_data_val is high in the same cycle, that pixel is (0,0) under the new configuration.
- Even row (y[0]=0):
  - Even x: pixel is held in a pair register.
  - Odd x: {held, current} is written to line buffer entry x>>1.
- Odd row (y[0]=1):
  - Even x: pixel is held as B0, and a read of entry x>>1 is issued. Read data is registered and held until the next read.
  - Odd x: current pixel is B1. With T0/T1 taken from the read data, the quad is complete.
- Quad mapping (R, G pair, B):
  - RGGB: R=T0, G=T1,B0, B=B1.
  - GRBG: R=T1, G=T0,B1, B=B0.
  - GBRG: R=B0, G=T0,B1, B=T1.
  - BGGR: R=B1, G=T1,B0, B=T0.
- Green = (Ga+Gb)>>1. The sum is computed at DATA_W+1 bits, floor rounding, with no overflow.
- o_x = x>>1 and o_y = y>>1 of the quad's B1 pixel.
- o_cfg_err is 1 in ERR and 0 otherwise.

## Timing
- Reset values: all outputs 0, state IDLE, x=y=0, pair register and read register 0.
- Latency: o_data_val rises exactly 1 cycle after the accept of B1, for one cycle. Colour and coordinate outputs update in that same cycle.
- Throughput: one pixel per cycle. Gaps in i_data_val of any length are allowed; state and partial quads are held across gaps.
- i_width and i_pattern changes outside i_sof have no effect.
- A partial row or quad truncated by i_sof or rst is discarded with no output.
- An i_sof arriving one cycle after a B1 accept does not suppress that pending output.

## Configuration
- BAYER_GREEN_AVG_EN defined: green = floor average of the two green samples, as above.
- BAYER_GREEN_AVG_EN undefined: green = the top-row green sample only (T1 for RGGB/BGGR, T0 for GRBG/GBRG). The adder is removed. All other behaviour is unchanged.

## Test plan
- RGGB and width 4, macro on. Row 0 = 100,200,300,400; row 1 = 500,600,700,800.
  - -> o_x=0, o_y=0: R=100, G=350, B=600.
  - -> o_x=1, o_y=0: R=300, G=550, B=800.
  - Each output is 1 cycle after its B1.
- Same data with i_pattern=3 (BGGR) -> first output B=100, G=350, R=600. Same data with pattern=1 (GRBG) -> first output R=200, G=350, B=500.
- Test 1 with random 0-5 cycle gaps in i_data_val -> identical output values and coordinates. Exactly 2 strobes per 2 rows.
- i_sof with i_width=5 -> o_cfg_err=1 and no o_data_val for 8 pixels. Next i_sof with i_width=4 -> o_cfg_err=0 and normal output.
- rst asserted mid row 1, then 8 pixels without i_sof -> no output, state IDLE.
- Greens 4095 and 4095 -> G=4095 with macro on. Greens 10 and 4095 -> G=2052 with macro on, G=T-row green without the macro.
